// File: rtl/stacker_pkg.sv
// Shared types and geometry for the stacker game datapath.
// The line counter width and column count are common to slider and comparator.
package stacker_pkg;

    localparam int COLS   = 8;
    localparam int LINES  = 8;
    localparam int LINE_W = 3;

    typedef enum logic [2:0] {
        MOVE  = 3'd0,
        WAIT  = 3'd1,
        CHECK = 3'd2,
        LOST  = 3'd3,
        WON   = 3'd4
    } state_t;

endpackage

// File: rtl/slide_ticker.sv
// Sliding block generator: tick counter, bouncing position and the live pattern.
// The tick period halves every two lines so later lines slide faster.
module slide_ticker
    import stacker_pkg::*;
#(
    parameter int BLOCK_W  = 3,
    parameter int TICK_DIV = 16
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_run,
    input  logic [LINE_W-1:0] i_line,
    output logic [COLS-1:0]   o_block_loc
);

    localparam int                CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W:0]    PERIOD0 = (CNT_W+1)'(TICK_DIV);
    localparam logic [CNT_W:0]    PER_ONE = (CNT_W+1)'(1);
    localparam logic [2:0]        POS_MAX = 3'(COLS - BLOCK_W);
    localparam logic [COLS-1:0]   MASK    = COLS'((1 << BLOCK_W) - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_pos;
    logic             r_dir;
    logic [CNT_W:0]   w_period;
    logic             w_tick;

    assign w_period = PERIOD0 >> i_line[2:1];
    assign w_tick   = ({1'b0, r_cnt} == (w_period - PER_ONE));

    // Endpoints turn around on the tick itself, so each end is shown for one full period.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
            r_pos <= '0;
            r_dir <= 1'b0;
        end else if (!i_run) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            if (!r_dir && r_pos == POS_MAX) begin
                r_dir <= 1'b1;
                r_pos <= r_pos - 3'd1;
            end else if (r_dir && r_pos == 3'd0) begin
                r_dir <= 1'b0;
                r_pos <= 3'd1;
            end else if (r_dir) begin
                r_pos <= r_pos - 3'd1;
            end else begin
                r_pos <= r_pos + 3'd1;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_block_loc = MASK << r_pos;

endmodule

// File: rtl/block_slider.sv
// Stacker upstream stage: freezes the sliding block on a press and acts on the comparator verdict.
//   state | meaning
//   MOVE  | block sliding, presses accepted
//   WAIT  | comparator registering the frozen block
//   CHECK | sample stacked verdict
//   LOST  | misaligned placement, press restarts
//   WON   | line 7 accepted, press restarts
module block_slider
    import stacker_pkg::*;
#(
    parameter int BLOCK_W  = 3,
    parameter int TICK_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
    input  logic              stacked,
    output logic [COLS-1:0]   blockLoc,
    output logic [COLS-1:0]   newBlockLoc,
    output logic [LINE_W-1:0] lineNum,
    output logic              gameOver,
    output logic              win
);

    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_btn_q;
    logic [COLS-1:0]   r_new_loc;
    logic [LINE_W-1:0] r_line;
    logic              r_over;
    logic              r_win;

    logic w_press;
    logic w_capture;
    logic w_line_inc;
    logic w_set_over;
    logic w_set_win;
    logic w_restart;
    logic w_clear;
    logic [COLS-1:0] w_block_loc;

    // Reset value of 1 keeps a button held through reset from counting as a press.
    always_ff @(posedge clk) begin
        if (rst) r_btn_q <= 1'b1;
        else     r_btn_q <= btn;
    end

    assign w_press = btn & ~r_btn_q;
    assign w_clear = rst | w_restart;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_line_inc  = 1'b0;
        w_set_over  = 1'b0;
        w_set_win   = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            MOVE: begin
                if (w_press) begin
                    w_capture   = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: w_state_nxt = CHECK;
            CHECK: begin
                if (r_line == '0 || stacked) begin
                    if (r_line == LINE_LAST) begin
                        w_set_win   = 1'b1;
                        w_state_nxt = WON;
                    end else begin
                        w_line_inc  = 1'b1;
                        w_state_nxt = MOVE;
                    end
                end else begin
                    w_set_over  = 1'b1;
                    w_state_nxt = LOST;
                end
            end
            LOST, WON: begin
                if (w_press) begin
                    w_restart   = 1'b1;
                    w_state_nxt = MOVE;
                end
            end
            default: w_state_nxt = MOVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state   <= MOVE;
            r_new_loc <= '0;
            r_line    <= '0;
            r_over    <= 1'b0;
            r_win     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture)  r_new_loc <= w_block_loc;
            if (w_line_inc) r_line    <= r_line + 3'd1;
            if (w_set_over) r_over    <= 1'b1;
            if (w_set_win)  r_win     <= 1'b1;
        end
    end

    slide_ticker #(
        .BLOCK_W  (BLOCK_W),
        .TICK_DIV (TICK_DIV)
    ) u_ticker (
        .clk         (clk),
        .i_clr       (w_clear),
        .i_run       (r_state == MOVE),
        .i_line      (r_line),
        .o_block_loc (w_block_loc)
    );

    assign blockLoc    = w_block_loc;
    assign newBlockLoc = r_new_loc;
    assign lineNum     = r_line;
    assign gameOver    = r_over;
    assign win         = r_win;

endmodule

// File: tb/tb_block_slider.sv
// Bench for block_slider with a behavioural game model and an exact-match comparator model.
module tb_block_slider;

    localparam int BLOCK_W  = 3;
    localparam int TICK_DIV = 16;

    localparam int M_MOVE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_CHECK = 2;
    localparam int M_LOST  = 3;
    localparam int M_WON   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       stacked = 1'b0;
    logic [7:0] blockLoc;
    logic [7:0] newBlockLoc;
    logic [2:0] lineNum;
    logic       gameOver;
    logic       win;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: game phase, line, frozen block, flags, total slide ticks and cycles into the current period.
    int         m_mode = M_MOVE;
    int         m_ln   = 0;
    logic [7:0] m_nb   = 8'h00;
    logic       m_go   = 1'b0;
    logic       m_wn   = 1'b0;
    int         m_T    = 0;
    int         m_m    = 0;
    logic       m_btnq = 1'b1;
    logic [7:0] m_stack = 8'h00;
    logic       m_stk   = 1'b0;

    block_slider #(.BLOCK_W(BLOCK_W), .TICK_DIV(TICK_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .stacked     (stacked),
        .blockLoc    (blockLoc),
        .newBlockLoc (newBlockLoc),
        .lineNum     (lineNum),
        .gameOver    (gameOver),
        .win         (win)
    );

    always #5 clk = ~clk;

    // The block bounces as a triangle wave over total tick count.
    function automatic logic [7:0] pat(input int t);
        int span, p, pos;
        span = 8 - BLOCK_W;
        p    = t % (2 * span);
        pos  = (p <= span) ? p : 2 * span - p;
        return 8'(((1 << BLOCK_W) - 1) << pos);
    endfunction

    function automatic int period(input int ln);
        return TICK_DIV >> (ln / 2);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("blockLoc",    blockLoc,           pat(m_T));
        chk("newBlockLoc", newBlockLoc,        m_nb);
        chk("lineNum",     {5'b0, lineNum},    8'(m_ln));
        chk("gameOver",    {7'b0, gameOver},   {7'b0, m_go});
        chk("win",         {7'b0, win},        {7'b0, m_wn});
    endtask

    task automatic game_clear();
        m_mode = M_MOVE;
        m_ln   = 0;
        m_nb   = 8'h00;
        m_go   = 1'b0;
        m_wn   = 1'b0;
        m_T    = 0;
        m_m    = 0;
    endtask

    task automatic step(input logic b, input logic r);
        logic [7:0] old_pat;
        logic [7:0] old_nb;
        logic       old_stk;
        logic       press;
        int         old_ln;
        btn = b;
        rst = r;
        @(posedge clk);
        #1;
        old_pat = pat(m_T);
        old_nb  = m_nb;
        old_stk = m_stk;
        old_ln  = m_ln;
        if (r) begin
            game_clear();
            m_btnq  = 1'b1;
            m_stack = 8'h00;
            m_stk   = 1'b0;
        end else begin
            press  = b & ~m_btnq;
            m_btnq = b;
            m_stk  = (old_nb == m_stack);
            if (old_ln == 0) m_stack = old_nb;
            case (m_mode)
                M_MOVE: begin
                    m_m++;
                    if (m_m == period(m_ln)) begin
                        m_m = 0;
                        m_T++;
                    end
                    if (press) begin
                        m_nb   = old_pat;
                        m_mode = M_WAIT;
                        m_m    = 0;
                    end
                end
                M_WAIT: m_mode = M_CHECK;
                M_CHECK: begin
                    if (old_ln == 0 || old_stk) begin
                        if (old_ln == 7) begin
                            m_wn   = 1'b1;
                            m_mode = M_WON;
                        end else begin
                            m_ln   = old_ln + 1;
                            m_mode = M_MOVE;
                        end
                    end else begin
                        m_go   = 1'b1;
                        m_mode = M_LOST;
                    end
                end
                default: if (press) game_clear();
            endcase
        end
        stacked = m_stk;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // Bounded wait until the live pattern shows the target, with btn low.
    task automatic wait_pat(input logic [7:0] target);
        step(1'b0, 1'b0);
        for (int i = 0; i < 400 && pat(m_T) != target; i++) step(1'b0, 1'b0);
        chk("wait_pat", blockLoc, target);
    endtask

    initial begin
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_blockLoc", blockLoc,    8'h07);
        chk("rst_newBlock", newBlockLoc, 8'h00);
        chk("rst_lineNum",  {5'b0, lineNum}, 8'h00);
        chk("rst_flags",    {6'b0, gameOver, win}, 8'h00);

        idle(15);
        chk("tick0", blockLoc, 8'h07);
        idle(1);
        chk("tick1", blockLoc, 8'h0E);
        idle(64);
        chk("tick5", blockLoc, 8'hE0);
        idle(16);
        chk("tick6_bounce", blockLoc, 8'h70);
        idle(64);
        chk("tick10", blockLoc, 8'h07);

        wait_pat(8'h07);
        step(1'b1, 1'b0);
        chk("l0_capture", newBlockLoc, 8'h07);
        idle(2);
        chk("l0_lineNum", {5'b0, lineNum}, 8'h01);
        chk("l0_gameOver", {7'b0, gameOver}, 8'h00);

        wait_pat(8'h0E);
        step(1'b1, 1'b0);
        idle(2);
        chk("miss_gameOver", {7'b0, gameOver}, 8'h01);
        chk("miss_lineNum",  {5'b0, lineNum}, 8'h01);
        idle(3);
        step(1'b1, 1'b0);
        chk("restart_newBlock", newBlockLoc, 8'h00);
        chk("restart_lineNum",  {5'b0, lineNum}, 8'h00);
        chk("restart_blockLoc", blockLoc, 8'h07);
        chk("restart_flags",    {6'b0, gameOver, win}, 8'h00);

        for (int k = 0; k < 8; k++) begin
            wait_pat(8'h07);
            step(1'b1, 1'b0);
            idle(2);
            chk("stack_lineNum", {5'b0, lineNum}, 8'((k < 7) ? k + 1 : 7));
            chk("stack_win", {7'b0, win}, {7'b0, (k == 7)});
        end
        idle(3);
        step(1'b1, 1'b0);

        wait_pat(8'h07);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
        chk("held_lineNum", {5'b0, lineNum}, 8'h01);

        wait_pat(8'h07);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        idle(20);
        chk("check_press_lineNum", {5'b0, lineNum}, 8'h02);

        wait_pat(8'h07);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("rstcheck_lineNum", {5'b0, lineNum}, 8'h00);
        chk("rstcheck_gameOver", {7'b0, gameOver}, 8'h00);
        chk("rstcheck_newBlock", newBlockLoc, 8'h00);
        idle(5);

        step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("held_rst_newBlock", newBlockLoc, 8'h00);
        idle(3);

        for (int i = 0; i < 3000; i++)
            step(logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 599) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
